// File: rtl/share_mem_arbiter.sv
// Round-robin arbiter giving two CPU ports shared access to one single-port
// synchronous RAM holding the inter-CPU mailbox window, with per-port write partitions.
module share_mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10,
  parameter logic [ADDR_W-1:0] WIN_BEGIN  = 22'h2000,
  parameter logic [ADDR_W-1:0] WIN_END    = 22'h23ff,
  parameter logic [ADDR_W-1:0] A_WR_BEGIN = 22'h2000,
  parameter logic [ADDR_W-1:0] A_WR_END   = 22'h21ff,
  parameter logic [ADDR_W-1:0] B_WR_BEGIN = 22'h2200,
  parameter logic [ADDR_W-1:0] B_WR_END   = 22'h23ff
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              A_req,
  input  logic              A_we,
  input  logic [ADDR_W-1:0] A_addr,
  input  logic [DATA_W-1:0] A_write_data,
  output logic              A_ack,
  output logic              A_err,
  output logic [DATA_W-1:0] A_read_data,
  input  logic              B_req,
  input  logic              B_we,
  input  logic [ADDR_W-1:0] B_addr,
  input  logic [DATA_W-1:0] B_write_data,
  output logic              B_ack,
  output logic              B_err,
  output logic [DATA_W-1:0] B_read_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t              state_reg, state_next;
  logic                grant_b_reg, grant_b_next;
  logic                last_b_reg, last_b_next;
  logic                we_reg, we_next;
  logic                err_reg, err_next;
  logic                a_ack_reg, a_ack_next, b_ack_reg, b_ack_next;
  logic                a_err_reg, a_err_next, b_err_reg, b_err_next;
  logic [DATA_W-1:0]   a_rd_reg, a_rd_next, b_rd_reg, b_rd_next;
  logic                mem_en_reg, mem_en_next, mem_we_reg, mem_we_next;
  logic [MEM_AW-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_din_reg, mem_din_next;

  logic                pick_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_err;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick_b   = B_req && (!A_req || !last_b_reg);
    sel_we   = pick_b ? B_we : A_we;
    sel_addr = pick_b ? B_addr : A_addr;
    sel_data = pick_b ? B_write_data : A_write_data;
    sel_err  = (sel_addr < WIN_BEGIN) || (sel_addr > WIN_END);
    if (sel_we) begin
      if (pick_b)
        sel_err = sel_err || (sel_addr < B_WR_BEGIN) || (sel_addr > B_WR_END);
      else
        sel_err = sel_err || (sel_addr < A_WR_BEGIN) || (sel_addr > A_WR_END);
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_b_next  = grant_b_reg;
    last_b_next   = last_b_reg;
    we_next       = we_reg;
    err_next      = err_reg;
    a_ack_next    = 1'b0;
    b_ack_next    = 1'b0;
    a_err_next    = 1'b0;
    b_err_next    = 1'b0;
    a_rd_next     = a_rd_reg;
    b_rd_next     = b_rd_reg;
    mem_en_next   = 1'b0;
    mem_we_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    case (state_reg)
      IDLE: begin
        if (A_req || B_req) begin
          grant_b_next  = pick_b;
          we_next       = sel_we;
          err_next      = sel_err;
          mem_en_next   = !sel_err;
          mem_we_next   = sel_we && !sel_err;
          mem_addr_next = sel_addr[MEM_AW-1:0];
          mem_din_next  = sel_data;
          state_next    = ISSUE;
        end
      end
      ISSUE: state_next = CAPTURE;
      CAPTURE: begin
        if (!we_reg) begin
          if (grant_b_reg) b_rd_next = err_reg ? '0 : mem_dout;
          else             a_rd_next = err_reg ? '0 : mem_dout;
        end
        a_ack_next = !grant_b_reg;
        a_err_next = !grant_b_reg && err_reg;
        b_ack_next = grant_b_reg;
        b_err_next = grant_b_reg && err_reg;
        state_next = ACK;
      end
      ACK: begin
        last_b_next = grant_b_reg;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_b_reg  <= 1'b0;
      last_b_reg   <= 1'b1;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      a_ack_reg    <= 1'b0;
      b_ack_reg    <= 1'b0;
      a_err_reg    <= 1'b0;
      b_err_reg    <= 1'b0;
      a_rd_reg     <= '0;
      b_rd_reg     <= '0;
      mem_en_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      grant_b_reg  <= grant_b_next;
      last_b_reg   <= last_b_next;
      we_reg       <= we_next;
      err_reg      <= err_next;
      a_ack_reg    <= a_ack_next;
      b_ack_reg    <= b_ack_next;
      a_err_reg    <= a_err_next;
      b_err_reg    <= b_err_next;
      a_rd_reg     <= a_rd_next;
      b_rd_reg     <= b_rd_next;
      mem_en_reg   <= mem_en_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
    end
  end

  assign A_ack       = a_ack_reg;
  assign A_err       = a_err_reg;
  assign A_read_data = a_rd_reg;
  assign B_ack       = b_ack_reg;
  assign B_err       = b_err_reg;
  assign B_read_data = b_rd_reg;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_din     = mem_din_reg;

endmodule

// File: tb/tb_share_mem_arbiter.sv
// Directed bench for share_mem_arbiter: a behavioural sync RAM stands in for the macro.
module tb_share_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        A_req, A_we, B_req, B_we;
  logic [21:0] A_addr, B_addr;
  logic [31:0] A_write_data, B_write_data;
  logic        A_ack, A_err, B_ack, B_err;
  logic [31:0] A_read_data, B_read_data;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_a_rd = '0;
  logic [31:0] exp_b_rd = '0;
  logic [31:0] ram [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
    end
  end

  share_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .A_req(A_req), .A_we(A_we), .A_addr(A_addr), .A_write_data(A_write_data),
    .A_ack(A_ack), .A_err(A_err), .A_read_data(A_read_data),
    .B_req(B_req), .B_we(B_we), .B_addr(B_addr), .B_write_data(B_write_data),
    .B_ack(B_ack), .B_err(B_err), .B_read_data(B_read_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One complete access on a single port; reads update the tracked read_data.
  task automatic access(input bit port_b, input bit we, input logic [21:0] addr,
                        input logic [31:0] wdata, input bit exp_err, input logic [31:0] rdata);
    logic [31:0] exp_rd;
    @(negedge clk);
    if (port_b) begin B_req = 1; B_we = we; B_addr = addr; B_write_data = wdata; end
    else        begin A_req = 1; A_we = we; A_addr = addr; A_write_data = wdata; end
    @(negedge clk);
    chk("mem_en_issue", {31'd0, mem_en}, {31'd0, !exp_err});
    chk("mem_we_issue", {31'd0, mem_we}, {31'd0, we && !exp_err});
    if (!exp_err) chk("mem_addr", {22'd0, mem_addr}, {22'd0, addr[9:0]});
    if (!exp_err && we) chk("mem_din", mem_din, wdata);
    chk("ack_early", {30'd0, A_ack, B_ack}, 32'd0);
    @(negedge clk);
    chk("mem_en_capture", {31'd0, mem_en}, 32'd0);
    chk("ack_early2", {30'd0, A_ack, B_ack}, 32'd0);
    @(negedge clk);
    if (!we) begin
      if (port_b) exp_b_rd = exp_err ? 32'd0 : rdata;
      else        exp_a_rd = exp_err ? 32'd0 : rdata;
    end
    exp_rd = port_b ? exp_b_rd : exp_a_rd;
    if (port_b) begin
      chk("b_ack", {30'd0, A_ack, B_ack}, 32'd1);
      chk("b_err", {31'd0, B_err}, {31'd0, exp_err});
      chk("b_rdata", B_read_data, exp_rd);
      chk("a_rdata_held", A_read_data, exp_a_rd);
      B_req = 0;
    end else begin
      chk("a_ack", {30'd0, A_ack, B_ack}, 32'd2);
      chk("a_err", {31'd0, A_err}, {31'd0, exp_err});
      chk("a_rdata", A_read_data, exp_rd);
      chk("b_rdata_held", B_read_data, exp_b_rd);
      A_req = 0;
    end
    $display("access port=%s we=%0d addr=%h wdata=%h err=%0b rdata=%h",
             port_b ? "B" : "A", we, addr, wdata, port_b ? B_err : A_err, exp_rd);
    @(negedge clk);
    chk("ack_pulse", {30'd0, A_ack, B_ack}, 32'd0);
  endtask

  // Both ports read continuously; A is expected to win the first tie.
  task automatic tie_run(input int ncyc);
    @(negedge clk);
    A_req = 1; A_we = 0; A_addr = 22'h2005;
    B_req = 1; B_we = 0; B_addr = 22'h2200;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk($sformatf("tie_a_ack_%0d", k), {31'd0, A_ack}, {31'd0, (k % 8) == 2});
      chk($sformatf("tie_b_ack_%0d", k), {31'd0, B_ack}, {31'd0, (k % 8) == 6});
      if ((k % 8) == 2) begin
        chk("tie_a_rdata", A_read_data, 32'hDEADBEEF);
        $display("tie cycle=%0d grant=A rdata=%h", k, A_read_data);
      end
      if ((k % 8) == 6) begin
        chk("tie_b_rdata", B_read_data, 32'h12345678);
        $display("tie cycle=%0d grant=B rdata=%h", k, B_read_data);
      end
    end
    A_req = 0; B_req = 0;
    exp_a_rd = 32'hDEADBEEF;
    exp_b_rd = 32'h12345678;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    A_req = 0; A_we = 0; A_addr = '0; A_write_data = '0;
    B_req = 0; B_we = 0; B_addr = '0; B_write_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {28'd0, A_ack, A_err, B_ack, B_err, mem_en, mem_we}, 32'd0);
    chk("rst_a_rd", A_read_data, 32'd0);
    chk("rst_b_rd", B_read_data, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    end

    access(0, 1, 22'h2005, 32'hDEADBEEF, 0, 32'd0);
    access(1, 0, 22'h2005, 32'd0, 0, 32'hDEADBEEF);
    access(1, 1, 22'h2005, 32'hBAD0BAD0, 1, 32'd0);
    access(0, 0, 22'h2005, 32'd0, 0, 32'hDEADBEEF);
    access(0, 0, 22'h2400, 32'd0, 1, 32'd0);
    access(0, 1, 22'h21FF, 32'hA5A5A5A5, 0, 32'd0);
    access(0, 1, 22'h2200, 32'h0BADF00D, 1, 32'd0);
    access(0, 0, 22'h1FFF, 32'd0, 1, 32'd0);
    access(1, 1, 22'h2200, 32'h12345678, 0, 32'd0);
    access(1, 1, 22'h23FF, 32'hCAFEF00D, 0, 32'd0);
    access(0, 0, 22'h21FF, 32'd0, 0, 32'hA5A5A5A5);
    access(1, 0, 22'h23FF, 32'd0, 0, 32'hCAFEF00D);

    // Last grant was B, so the tie starts with A.
    tie_run(16);

    // Abandon an A read in its CAPTURE cycle.
    @(negedge clk);
    A_req = 1; A_we = 0; A_addr = 22'h2005;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_a_rd", A_read_data, 32'd0);
    chk("rst_mid_outs", {28'd0, A_ack, A_err, B_ack, B_err, mem_en, mem_we}, 32'd0);
    A_req = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", {31'd0, A_ack}, 32'd0);
      chk("rst_mid_a_rd0", A_read_data, 32'd0);
    end
    $display("reset mid-capture: A access abandoned");
    tie_run(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
